// File: rtl/freqchk_pkg.sv
// freqchk shared types: state encoding, count width, range helper.
// Imported by the interface, watchdog and top.
package freqchk_pkg;

  localparam int CW = 29;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_ACQ  = 2'b01,
    ST_LOCK = 2'b10,
    ST_FAIL = 2'b11
  } state_e;

  localparam cnt_t CNT_ONES = '1;

  function automatic logic in_range(
    input cnt_t v,
    input cnt_t lo,
    input cnt_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/freqchk_if.sv
// freqchk measurement input bundle and status/statistics outputs.
// master drives the measurement side, slave is the checker.
interface freqchk_if;
  import freqchk_pkg::*;

  cnt_t       oval;
  logic       ovld;
  logic       clr;
  logic [1:0] state;
  logic       locked;
  logic       alarm;
  logic       tmo;
  logic [7:0] errcnt;
  cnt_t       fmin;
  cnt_t       fmax;
  cnt_t       flast;

  modport master (
    output oval, ovld, clr,
    input  state, locked, alarm, tmo,
    input  errcnt, fmin, fmax, flast
  );

  modport slave (
    input  oval, ovld, clr,
    output state, locked, alarm, tmo,
    output errcnt, fmin, fmax, flast
  );

endinterface

// File: rtl/freqchk_wdog.sv
// Missing-measurement watchdog: counts strobe-free cycles, holds at
// TIMEOUT and pulses fire on the cycle the count reaches TIMEOUT.
module freqchk_wdog
  import freqchk_pkg::*;
#(
  parameter cnt_t TIMEOUT = 29'd150000000
) (
  input  logic clkmon,
  input  logic rstn,
  input  logic strobe,
  output logic fire
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    fire  = 1'b0;
    if (strobe) begin
      cnt_d = '0;
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + cnt_t'(1);
      fire  = (cnt_d == TIMEOUT);
    end
  end

  always_ff @(posedge clkmon or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/freqchk.sv
// Frequency checker: range compare, lock/fail hysteresis FSM with
// watchdog, sticky alarm and min/max/error statistics.
module freqchk
  import freqchk_pkg::*;
#(
  parameter cnt_t       LOWLIM    = 29'd124987500,
  parameter cnt_t       HIGHLIM   = 29'd125012500,
  parameter logic [3:0] LOCKCNT   = 4'd4,
  parameter logic [3:0] UNLOCKCNT = 4'd2,
  parameter cnt_t       TIMEOUT   = 29'd150000000
) (
  input logic     clkmon,
  input logic     rstn,
  freqchk_if.slave bus
);

  logic stb, clr, in_rng, fire;
  cnt_t oval;

  assign stb    = bus.ovld;
  assign clr    = bus.clr;
  assign oval   = bus.oval;
  assign in_rng = in_range(oval, LOWLIM, HIGHLIM);

  freqchk_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clkmon (clkmon),
    .rstn   (rstn),
    .strobe (stb),
    .fire   (fire)
  );

  state_e     state_q, state_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic       locked_q, locked_d;
  logic       alarm_q, alarm_d;
  logic       tmo_q, tmo_d;
  logic       alarm_set;

  always_ff @(posedge clkmon or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_INIT;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      alarm_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      alarm_q  <= alarm_d;
      tmo_q    <= tmo_d;
    end
  end

  // A strobe always takes priority over a same-cycle watchdog fire.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (stb) begin
      unique case (state_q)
        ST_INIT: begin
          state_d = ST_ACQ;
          good_d  = '0;
        end
        ST_ACQ: begin
          if (in_rng) begin
            good_d = good_q + 4'd1;
            if (good_d == LOCKCNT) begin
              state_d = ST_LOCK;
              bad_d   = '0;
            end
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_LOCK: begin
          if (in_rng) begin
            bad_d = '0;
          end else begin
            bad_d = bad_q + 4'd1;
            if (bad_d == UNLOCKCNT) state_d = ST_FAIL;
          end
        end
        ST_FAIL: begin
          if (in_rng) begin
            if (LOCKCNT == 4'd1) begin
              state_d = ST_LOCK;
              bad_d   = '0;
            end else begin
              state_d = ST_ACQ;
              good_d  = 4'd1;
            end
          end
        end
      endcase
    end else if (fire) begin
      state_d = ST_FAIL;
      good_d  = '0;
      bad_d   = '0;
    end
  end

  always_comb begin
    locked_d  = (state_d == ST_LOCK);
    alarm_set = (!stb && fire) ||
                (state_q == ST_LOCK && state_d == ST_FAIL);
    alarm_d   = alarm_q;
    if (clr)       alarm_d = 1'b0;
    if (alarm_set) alarm_d = 1'b1;
    tmo_d = tmo_q;
    if (stb)       tmo_d = 1'b0;
    else if (fire) tmo_d = 1'b1;
  end

  logic [7:0] err_q, err_d;
  cnt_t       fmin_q, fmin_d;
  cnt_t       fmax_q, fmax_d;
  cnt_t       flast_q, flast_d;
  logic       acc;

  assign acc = stb && (state_q != ST_INIT);

  // clr resets first, then an accepted sample lands on top of it.
  always_comb begin
    err_d   = err_q;
    fmin_d  = fmin_q;
    fmax_d  = fmax_q;
    flast_d = flast_q;
    if (clr) begin
      err_d  = '0;
      fmin_d = CNT_ONES;
      fmax_d = '0;
    end
    if (acc) begin
      flast_d = oval;
      if (oval < fmin_d) fmin_d = oval;
      if (oval > fmax_d) fmax_d = oval;
      if (!in_rng && err_d != 8'hFF) err_d = err_d + 8'd1;
    end
  end

  always_ff @(posedge clkmon or negedge rstn) begin
    if (!rstn) begin
      err_q   <= '0;
      fmin_q  <= CNT_ONES;
      fmax_q  <= '0;
      flast_q <= '0;
    end else begin
      err_q   <= err_d;
      fmin_q  <= fmin_d;
      fmax_q  <= fmax_d;
      flast_q <= flast_d;
    end
  end

  assign bus.state  = state_q;
  assign bus.locked = locked_q;
  assign bus.alarm  = alarm_q;
  assign bus.tmo    = tmo_q;
  assign bus.errcnt = err_q;
  assign bus.fmin   = fmin_q;
  assign bus.fmax   = fmax_q;
  assign bus.flast  = flast_q;

endmodule

// File: tb/tb_freqchk.sv
// Directed-vector bench for freqchk with TIMEOUT shortened to 100.
// Table vectors plus hand sequences for timeout, saturation, reset.
module tb_freqchk;

  localparam logic [28:0] ONES = 29'h1FFFFFFF;
  localparam logic [28:0] NOM  = 29'd125000000;
  localparam logic [28:0] LOW  = 29'd124000000;
  localparam logic [28:0] HI2  = 29'd125020000;
  localparam logic [28:0] LLIM = 29'd124987500;
  localparam logic [28:0] HLIM = 29'd125012500;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  freqchk_if bus ();

  freqchk #(
    .TIMEOUT (29'd100)
  ) dut (
    .clkmon (clk),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] oval;
    logic        clr;
    logic [1:0]  st;
    logic        lk;
    logic        al;
    logic        tm;
    logic [7:0]  err;
    logic [28:0] mn;
    logic [28:0] mx;
    logic [28:0] last;
  } vec_t;

  function automatic vec_t mk(
    input logic [28:0] oval, input logic clr,
    input logic [1:0] st, input logic lk,
    input logic al, input logic tm,
    input logic [7:0] err, input logic [28:0] mn,
    input logic [28:0] mx, input logic [28:0] last
  );
    vec_t v;
    v.oval = oval; v.clr = clr; v.st = st; v.lk = lk;
    v.al = al; v.tm = tm; v.err = err;
    v.mn = mn; v.mx = mx; v.last = last;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".state"}, 32'(bus.state), 32'(v.st));
    chk({tag, ".locked"}, 32'(bus.locked), 32'(v.lk));
    chk({tag, ".alarm"}, 32'(bus.alarm), 32'(v.al));
    chk({tag, ".tmo"}, 32'(bus.tmo), 32'(v.tm));
    chk({tag, ".errcnt"}, 32'(bus.errcnt), 32'(v.err));
    chk({tag, ".fmin"}, 32'(bus.fmin), 32'(v.mn));
    chk({tag, ".fmax"}, 32'(bus.fmax), 32'(v.mx));
    chk({tag, ".flast"}, 32'(bus.flast), 32'(v.last));
  endtask

  task automatic strobe(input logic [28:0] val, input logic c);
    @(negedge clk);
    bus.oval = val;
    bus.ovld = 1'b1;
    bus.clr  = c;
    @(negedge clk);
    bus.ovld = 1'b0;
    bus.clr  = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    strobe(v.oval, v.clr);
    chk_all(tag, v);
  endtask

  vec_t vt[18];

  initial begin
    bus.oval = '0;
    bus.ovld = 1'b0;
    bus.clr  = 1'b0;

    vt[0]  = mk(29'd0, 0, 1, 0, 0, 0, 0, ONES, 0, 0);
    vt[1]  = mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM);
    vt[2]  = mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM);
    vt[3]  = mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM);
    vt[4]  = mk(NOM, 0, 2, 1, 0, 0, 0, NOM, NOM, NOM);
    vt[5]  = mk(HI2, 0, 2, 1, 0, 0, 1, NOM, HI2, HI2);
    vt[6]  = mk(NOM, 0, 2, 1, 0, 0, 1, NOM, HI2, NOM);
    vt[7]  = mk(LOW, 0, 2, 1, 0, 0, 2, LOW, HI2, LOW);
    vt[8]  = mk(LOW, 0, 3, 0, 1, 0, 3, LOW, HI2, LOW);
    vt[9]  = mk(LLIM, 0, 1, 0, 1, 0, 3, LOW, HI2, LLIM);
    vt[10] = mk(HLIM, 0, 1, 0, 1, 0, 3, LOW, HI2, HLIM);
    vt[11] = mk(LLIM - 29'd1, 0, 3, 0, 1, 0, 4,
                LOW, HI2, LLIM - 29'd1);
    vt[12] = mk(HLIM, 0, 1, 0, 1, 0, 4, LOW, HI2, HLIM);
    vt[13] = mk(HLIM + 29'd1, 0, 3, 0, 1, 0, 5,
                LOW, HI2, HLIM + 29'd1);
    vt[14] = mk(NOM, 1, 1, 0, 0, 0, 0, NOM, NOM, NOM);
    vt[15] = mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM);
    vt[16] = mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM);
    vt[17] = mk(NOM, 0, 2, 1, 0, 0, 0, NOM, NOM, NOM);

    repeat (2) @(negedge clk);
    chk_all("reset", mk(0, 0, 0, 0, 0, 0, 0, ONES, 0, 0));
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply($sformatf("v%0d", i), vt[i]);
    end

    // Watchdog: last strobe edge was P0; fires after P100.
    repeat (99) @(negedge clk);
    chk("wd_pre.state", 32'(bus.state), 32'd2);
    chk("wd_pre.tmo", 32'(bus.tmo), 32'd0);
    @(negedge clk);
    chk("wd.state", 32'(bus.state), 32'd3);
    chk("wd.tmo", 32'(bus.tmo), 32'd1);
    chk("wd.alarm", 32'(bus.alarm), 32'd1);
    chk("wd.locked", 32'(bus.locked), 32'd0);
    apply("wd_rec", mk(NOM, 0, 1, 0, 1, 0, 0, NOM, NOM, NOM));

    strobe(LOW, 1'b1);
    chk("clr_oor.state", 32'(bus.state), 32'd3);
    chk("clr_oor.errcnt", 32'(bus.errcnt), 32'd1);
    chk("clr_oor.fmin", 32'(bus.fmin), 32'(LOW));
    chk("clr_oor.fmax", 32'(bus.fmax), 32'(LOW));

    // 300 back-to-back out-of-range strobes saturate errcnt.
    @(negedge clk);
    bus.oval = LOW;
    bus.ovld = 1'b1;
    repeat (300) @(negedge clk);
    bus.ovld = 1'b0;
    chk("sat.errcnt", 32'(bus.errcnt), 32'd255);
    chk("sat.state", 32'(bus.state), 32'd3);
    chk("sat.tmo", 32'(bus.tmo), 32'd0);

    apply("r1", mk(NOM, 0, 1, 0, 0, 0, 255, LOW, NOM, NOM));
    apply("r2", mk(NOM, 0, 1, 0, 0, 0, 255, LOW, NOM, NOM));
    apply("r3", mk(NOM, 0, 1, 0, 0, 0, 255, LOW, NOM, NOM));
    apply("r4", mk(NOM, 0, 2, 1, 0, 0, 255, LOW, NOM, NOM));
    apply("b1", mk(LOW, 0, 2, 1, 0, 0, 255, LOW, NOM, LOW));
    // Alarm set from the LOCK drop wins over the same-cycle clr.
    apply("b2", mk(LOW, 1, 3, 0, 1, 0, 1, LOW, LOW, LOW));

    apply("l1", mk(NOM, 0, 1, 0, 1, 0, 1, LOW, NOM, NOM));
    apply("l2", mk(NOM, 0, 1, 0, 1, 0, 1, LOW, NOM, NOM));
    apply("l3", mk(NOM, 0, 1, 0, 1, 0, 1, LOW, NOM, NOM));
    apply("l4", mk(NOM, 0, 2, 1, 1, 0, 1, LOW, NOM, NOM));

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk_all("arst", mk(0, 0, 0, 0, 0, 0, 0, ONES, 0, 0));
    @(negedge clk);
    rstn = 1'b1;
    apply("p0", mk(NOM, 0, 1, 0, 0, 0, 0, ONES, 0, 0));
    apply("p1", mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM));
    apply("p2", mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM));
    apply("p3", mk(NOM, 0, 1, 0, 0, 0, 0, NOM, NOM, NOM));
    apply("p4", mk(NOM, 0, 2, 1, 0, 0, 0, NOM, NOM, NOM));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
